// File: rtl/host_write_control_pkg.sv
// Shared types and constants for the host-side packet RAM writer.
package host_write_control_pkg;

    localparam int PKT_W    = 134;
    localparam int BUFID_W  = 9;
    localparam int OFFS_W   = 7;
    localparam int INPORT_W = 4;
    localparam int ADDR_W   = BUFID_W + OFFS_W;
    localparam int DESC_W   = INPORT_W + BUFID_W;
    localparam int CNT_W    = 16;

    localparam int HEAD_BIT = 133;
    localparam int TAIL_BIT = 132;

    localparam logic [INPORT_W-1:0] RESERVED_INPORT = 4'hf;
    localparam logic [OFFS_W-1:0]   OFFS_MAX        = 7'h7f;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd1;
    localparam logic [2:0] ST_WAIT_DATA = 3'd2;
    localparam logic [2:0] ST_DESC      = 3'd3;
    localparam logic [2:0] ST_DISCARD   = 3'd4;

    typedef enum logic [2:0] {
        IDLE_S      = ST_IDLE,
        WAIT_ACK_S  = ST_WAIT_ACK,
        WAIT_DATA_S = ST_WAIT_DATA,
        DESC_S      = ST_DESC,
        DISCARD_S   = ST_DISCARD
    } state_t;

endpackage

// File: rtl/host_write_control.sv
// Writes host RX beats into packet RAM at {bufid,offset} and issues {inport,bufid} descriptors.
// Optional HWC_DROP_NO_BUFID_EN: drop heads instead of stalling when no free bufid exists.
module host_write_control
    import host_write_control_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [PKT_W-1:0]     iv_pkt_data,
    input  logic                 i_pkt_data_wr,
    output logic                 o_pkt_data_ready,
    input  logic [INPORT_W-1:0]  iv_pkt_inport,
    input  logic [BUFID_W-1:0]   iv_pkt_bufid,
    input  logic                 i_pkt_bufid_valid,
    output logic                 o_pkt_bufid_rd,
    output logic [ADDR_W-1:0]    ov_pkt_waddr,
    output logic [PKT_W-1:0]     ov_pkt_wdata,
    output logic                 o_pkt_wr,
    input  logic                 i_pkt_waddr_ack,
    output logic [DESC_W-1:0]    ov_pkt_descriptor,
    output logic                 o_pkt_descriptor_wr,
    input  logic                 i_descriptor_full,
    output logic [CNT_W-1:0]     ov_pkt_cnt,
    output logic [CNT_W-1:0]     ov_drop_cnt
);

    state_t state, next_state;

    logic [BUFID_W-1:0]  bufid_r;
    logic [INPORT_W-1:0] inport_r;
    logic [OFFS_W-1:0]   offset_r;
    logic [OFFS_W-1:0]   offset_next;
    logic                trunc_r;
    logic                last_tail_r;

    logic beat_fire, beat_head, beat_tail;
    logic take_head, write_next, ack_done, drop_evt, set_trunc, desc_fire;

    assign beat_fire   = i_pkt_data_wr & o_pkt_data_ready;
    assign beat_head   = iv_pkt_data[HEAD_BIT];
    assign beat_tail   = iv_pkt_data[TAIL_BIT];
    assign offset_next = offset_r + 7'd1;

    always_comb begin
        o_pkt_data_ready = 1'b0;
        case (state)
`ifdef HWC_DROP_NO_BUFID_EN
            IDLE_S:                 o_pkt_data_ready = 1'b1;
`else
            IDLE_S:                 o_pkt_data_ready = i_pkt_bufid_valid;
`endif
            WAIT_DATA_S, DISCARD_S: o_pkt_data_ready = 1'b1;
            default:                o_pkt_data_ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE_S;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        take_head  = 1'b0;
        write_next = 1'b0;
        ack_done   = 1'b0;
        drop_evt   = 1'b0;
        set_trunc  = 1'b0;
        desc_fire  = 1'b0;
        case (state)
            IDLE_S: begin
                if (beat_fire) begin
                    if (beat_head && iv_pkt_inport != RESERVED_INPORT && i_pkt_bufid_valid) begin
                        take_head  = 1'b1;
                        next_state = WAIT_ACK_S;
                    end else if (beat_head) begin
                        drop_evt   = 1'b1;
                        next_state = beat_tail ? IDLE_S : DISCARD_S;
                    end else begin
                        drop_evt   = 1'b1;
                    end
                end
            end
            WAIT_ACK_S: begin
                if (i_pkt_waddr_ack) begin
                    ack_done   = 1'b1;
                    next_state = last_tail_r ? DESC_S : WAIT_DATA_S;
                end
            end
            WAIT_DATA_S: begin
                // Head bit is ignored mid-packet; beyond the last offset beats are only counted once.
                if (beat_fire) begin
                    if (offset_r != OFFS_MAX) begin
                        write_next = 1'b1;
                        next_state = WAIT_ACK_S;
                    end else begin
                        if (!trunc_r) begin
                            drop_evt  = 1'b1;
                            set_trunc = 1'b1;
                        end
                        if (beat_tail) next_state = DESC_S;
                    end
                end
            end
            DESC_S: begin
                if (!i_descriptor_full) begin
                    desc_fire  = 1'b1;
                    next_state = IDLE_S;
                end
            end
            DISCARD_S: begin
                if (beat_fire && beat_tail) next_state = IDLE_S;
            end
            default: next_state = IDLE_S;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bufid_r        <= '0;
            inport_r       <= '0;
            offset_r       <= '0;
            trunc_r        <= 1'b0;
            last_tail_r    <= 1'b0;
            o_pkt_bufid_rd <= 1'b0;
            ov_pkt_waddr   <= '0;
            ov_pkt_wdata   <= '0;
            o_pkt_wr       <= 1'b0;
        end else begin
            o_pkt_bufid_rd <= take_head;
            if (take_head) begin
                bufid_r      <= iv_pkt_bufid;
                inport_r     <= iv_pkt_inport;
                offset_r     <= '0;
                trunc_r      <= 1'b0;
                last_tail_r  <= beat_tail;
                ov_pkt_waddr <= {iv_pkt_bufid, {OFFS_W{1'b0}}};
                ov_pkt_wdata <= iv_pkt_data;
                o_pkt_wr     <= 1'b1;
            end else if (write_next) begin
                offset_r     <= offset_next;
                last_tail_r  <= beat_tail;
                ov_pkt_waddr <= {bufid_r, offset_next};
                ov_pkt_wdata <= iv_pkt_data;
                o_pkt_wr     <= 1'b1;
            end else if (ack_done) begin
                o_pkt_wr     <= 1'b0;
            end
            if (set_trunc) trunc_r <= 1'b1;
        end
    end

    assign o_pkt_descriptor_wr = desc_fire;
    assign ov_pkt_descriptor   = desc_fire ? {inport_r, bufid_r} : '0;

    // Statistics counters wrap naturally at 16 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_pkt_cnt  <= '0;
            ov_drop_cnt <= '0;
        end else begin
            if (desc_fire) ov_pkt_cnt  <= ov_pkt_cnt + 16'd1;
            if (drop_evt)  ov_drop_cnt <= ov_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_host_write_control.sv
// Directed self-checking bench for host_write_control; a negedge monitor also plays the RAM ack side.
`timescale 1ns/1ps
module tb_host_write_control;
    import host_write_control_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [PKT_W-1:0]    pkt_data;
    logic                pkt_wr;
    logic                pkt_ready;
    logic [INPORT_W-1:0] pkt_inport;
    logic [BUFID_W-1:0]  pkt_bufid;
    logic                bufid_valid;
    logic                bufid_rd;
    logic [ADDR_W-1:0]   waddr;
    logic [PKT_W-1:0]    wdata;
    logic                ram_wr;
    logic                ack;
    logic [DESC_W-1:0]   descriptor;
    logic                descriptor_wr;
    logic                desc_full;
    logic [CNT_W-1:0]    pkt_cnt;
    logic [CNT_W-1:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    int ack_delay = 0, wait_cnt = 0, cyc = 0;
    int pop_count = 0, wr_count = 0, desc_count = 0;
    int held = 0, ack_cycle = 0, desc_cycle = 0, addr_glitch = 0;
    logic [15:0] wr_log [0:255];
    logic [31:0] wr_data_log [0:255];
    logic [12:0] last_desc = '0;
    logic [15:0] prev_waddr = '0;

`ifdef HWC_DROP_NO_BUFID_EN
    localparam int EXP_T5_PKTS = 3;
    localparam int EXP_T5_DROP = 4;
    localparam int EXP_T5_WR   = 132;
`else
    localparam int EXP_T5_PKTS = 4;
    localparam int EXP_T5_DROP = 3;
    localparam int EXP_T5_WR   = 133;
`endif

    always #5 clk = ~clk;

    host_write_control dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .iv_pkt_data         (pkt_data),
        .i_pkt_data_wr       (pkt_wr),
        .o_pkt_data_ready    (pkt_ready),
        .iv_pkt_inport       (pkt_inport),
        .iv_pkt_bufid        (pkt_bufid),
        .i_pkt_bufid_valid   (bufid_valid),
        .o_pkt_bufid_rd      (bufid_rd),
        .ov_pkt_waddr        (waddr),
        .ov_pkt_wdata        (wdata),
        .o_pkt_wr            (ram_wr),
        .i_pkt_waddr_ack     (ack),
        .ov_pkt_descriptor   (descriptor),
        .o_pkt_descriptor_wr (descriptor_wr),
        .i_descriptor_full   (desc_full),
        .ov_pkt_cnt          (pkt_cnt),
        .ov_drop_cnt         (drop_cnt)
    );

    // Mid-cycle observer and RAM responder: acks a write ack_delay+1 cycles after it appears.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack      = 1'b0;
            wait_cnt = 0;
        end else begin
            if (bufid_rd) pop_count++;
            if (descriptor_wr) begin
                desc_count++;
                last_desc  = descriptor;
                desc_cycle = cyc;
            end
            if (ram_wr) begin
                if (wait_cnt > 0 && waddr !== prev_waddr) addr_glitch++;
                prev_waddr = waddr;
                wait_cnt++;
                ack = (wait_cnt > ack_delay);
                if (ack) begin
                    if (wr_count < 256) begin
                        wr_log[wr_count]      = waddr;
                        wr_data_log[wr_count] = wdata[31:0];
                    end
                    wr_count++;
                    held      = wait_cnt;
                    ack_cycle = cyc;
                end
            end else begin
                wait_cnt = 0;
                ack      = 1'b0;
            end
        end
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [133:0] observed, input logic [133:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic head, input logic tail, input logic [3:0] inport,
                                 input logic [31:0] payload);
        bit accepted;
        accepted             = 1'b0;
        pkt_data             = '0;
        pkt_data[HEAD_BIT]   = head;
        pkt_data[TAIL_BIT]   = tail;
        pkt_data[31:0]       = payload;
        pkt_inport           = inport;
        pkt_wr               = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (pkt_ready) accepted = 1'b1;
            @(posedge clk);
        end
        #1 pkt_wr = 1'b0;
        checks++;
        assert (accepted)
        else begin
            errors++;
            $error("[TB] FAIL beat_accept observed=%0d expected=1", accepted);
        end
    endtask

    task automatic wait_writes(input int target);
        for (int i = 0; i < 300 && wr_count < target; i++) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ready_seen;
        int exp_cyc;
        int base_desc;

        rst_n       = 1'b0;
        pkt_data    = '0;
        pkt_wr      = 1'b0;
        pkt_inport  = '0;
        pkt_bufid   = '0;
        bufid_valid = 1'b0;
        desc_full   = 1'b0;

        repeat (3) @(negedge clk);
`ifdef HWC_DROP_NO_BUFID_EN
        checkOutput("rst_ready", pkt_ready, 1'b1);
`else
        checkOutput("rst_ready", pkt_ready, 1'b0);
`endif
        checkOutput("rst_wr", ram_wr, 1'b0);
        checkOutput("rst_waddr", waddr, 16'h0000);
        checkOutput("rst_bufid_rd", bufid_rd, 1'b0);
        checkOutput("rst_desc_wr", descriptor_wr, 1'b0);
        checkOutput("rst_desc", descriptor, 13'h0);
        checkOutput("rst_pkt_cnt", pkt_cnt, 16'h0);
        checkOutput("rst_drop_cnt", drop_cnt, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 1: 3-beat packet, inport 2, bufid 0x05");
        pkt_bufid   = 9'h005;
        bufid_valid = 1'b1;
        ack_delay   = 0;
        applyStimulus(1'b1, 1'b0, 4'h2, 32'h1000);
        applyStimulus(1'b0, 1'b0, 4'h2, 32'h1001);
        applyStimulus(1'b0, 1'b1, 4'h2, 32'h1002);
        wait_writes(3);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t1_waddr0", wr_log[0], 16'h0280);
        checkOutput("t1_waddr1", wr_log[1], 16'h0281);
        checkOutput("t1_waddr2", wr_log[2], 16'h0282);
        checkOutput("t1_wdata1", wr_data_log[1], 32'h1001);
        checkOutput("t1_pops", pop_count, 1);
        checkOutput("t1_desc", last_desc, 13'h0405);
        checkOutput("t1_pkt_cnt", pkt_cnt, 16'd1);

        $display("[TB] test 2: single-beat packet, bufid 0x1ff, slow ack");
        pkt_bufid = 9'h1ff;
        ack_delay = 4;
        applyStimulus(1'b1, 1'b1, 4'h3, 32'h2000);
        wait_writes(4);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t2_waddr", wr_log[3], 16'hff80);
        checkOutput("t2_held", held, 5);
        checkOutput("t2_addr_stable", addr_glitch, 0);
        checkOutput("t2_desc", last_desc, 13'h07ff);
        checkOutput("t2_desc_timing", desc_cycle, ack_cycle + 1);
        checkOutput("t2_count", desc_count, 2);

        $display("[TB] test 3: 130-beat packet truncates at 128 beats");
        pkt_bufid = 9'h00a;
        ack_delay = 0;
        for (int b = 0; b < 130; b++)
            applyStimulus(b == 0, b == 129, 4'h1, b);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t3_writes", wr_count, 132);
        checkOutput("t3_first", wr_log[4], 16'h0500);
        checkOutput("t3_last", wr_log[131], 16'h057f);
        checkOutput("t3_last_data", wr_data_log[131], 32'd127);
        checkOutput("t3_drop_cnt", drop_cnt, 16'd1);
        checkOutput("t3_desc", last_desc, 13'h020a);
        checkOutput("t3_pkt_cnt", pkt_cnt, 16'd3);

        $display("[TB] test 4: reserved inport discard, then orphan beat");
        applyStimulus(1'b1, 1'b0, 4'hf, 32'h4000);
        applyStimulus(1'b0, 1'b0, 4'hf, 32'h4001);
        applyStimulus(1'b0, 1'b1, 4'hf, 32'h4002);
        applyStimulus(1'b0, 1'b1, 4'h4, 32'h4003);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4_pops", pop_count, 3);
        checkOutput("t4_writes", wr_count, 132);
        checkOutput("t4_descs", desc_count, 3);
        checkOutput("t4_drop_cnt", drop_cnt, 16'd3);

        $display("[TB] test 5: no free bufid at head arrival");
        pkt_bufid   = 9'h033;
        bufid_valid = 1'b0;
`ifdef HWC_DROP_NO_BUFID_EN
        applyStimulus(1'b1, 1'b1, 4'h5, 32'h5000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_no_pop", pop_count, 3);
        bufid_valid = 1'b1;
`else
        pkt_data           = '0;
        pkt_data[HEAD_BIT] = 1'b1;
        pkt_data[TAIL_BIT] = 1'b1;
        pkt_inport         = 4'h5;
        pkt_wr             = 1'b1;
        ready_seen         = 0;
        repeat (10) begin
            @(negedge clk);
            if (pkt_ready) ready_seen++;
        end
        checkOutput("t5_stall_ready", ready_seen, 0);
        checkOutput("t5_no_pop", pop_count, 3);
        @(posedge clk);
        #1 bufid_valid = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'h5, 32'h5000);
        wait_writes(133);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5_waddr", wr_log[132], 16'h1980);
        checkOutput("t5_desc", last_desc, 13'h0a33);
`endif
        checkOutput("t5_pkt_cnt", pkt_cnt, EXP_T5_PKTS);
        checkOutput("t5_drop_cnt", drop_cnt, EXP_T5_DROP);

        $display("[TB] test 6: descriptor FIFO full after tail ack");
        pkt_bufid = 9'h044;
        desc_full = 1'b1;
        base_desc = desc_count;
        applyStimulus(1'b1, 1'b0, 4'h6, 32'h6000);
        applyStimulus(1'b0, 1'b1, 4'h6, 32'h6001);
        wait_writes(EXP_T5_WR + 2);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t6_held_back", desc_count, base_desc);
        checkOutput("t6_ready_blocked", pkt_ready, 1'b0);
        desc_full = 1'b0;
        exp_cyc   = cyc;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_desc_timing", desc_cycle, exp_cyc);
        checkOutput("t6_once", desc_count, base_desc + 1);
        checkOutput("t6_desc", last_desc, 13'h0c44);
        checkOutput("t6_pops", pop_count, EXP_T5_PKTS + 1);
        checkOutput("t6_pkt_cnt", pkt_cnt, EXP_T5_PKTS + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
